// File: rtl/dmem_responder.sv
// Memory-stage data responder: byte-enabled synchronous RAM below MMIO_BASE and a
// stalling valid/ready peripheral port with a timeout at or above it.
module dmem_responder #(
  parameter int unsigned DEPTH      = 16384,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
  parameter int unsigned IO_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_we,
  input  logic        req_re,
  input  logic [1:0]  req_bytes,
  input  logic        req_unsigned,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misaligned,
  output logic        io_valid,
  output logic [31:0] io_addr,
  output logic [31:0] io_wdata,
  output logic [3:0]  io_be,
  output logic        io_we,
  input  logic        io_ready,
  input  logic [31:0] io_rdata,
  output logic [1:0]  dbg_state
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (IO_TIMEOUT > 1) ? $clog2(IO_TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, IO_REQ = 2'd1, IO_DONE = 2'd2} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   io_hold_q;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   ram_rd_q;
  logic          ram_load_q;
  logic [1:0]    lane_q, size_q;
  logic          uns_q;
  logic          misaligned_q;

  logic          misalign, accept, bad, is_mmio, ram_we, ram_re, io_start;
  logic [3:0]    be;
  logic [31:0]   wrep;
  logic [AW-1:0] idx;

  logic [31:0]   mem [DEPTH];

  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] lane,
                                              input logic [1:0] size, input logic uns);
    logic [31:0] sh;
    logic [15:0] h;
    sh = w >> {lane, 3'b000};
    h  = lane[1] ? w[31:16] : w[15:0];
    case (size)
      2'b00:   return uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'b01:   return uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  always_comb begin
    be       = 4'b1111;
    wrep     = req_wdata;
    misalign = |req_addr[1:0];
    case (req_bytes)
      2'b00: begin
        be       = 4'b0001 << req_addr[1:0];
        wrep     = {4{req_wdata[7:0]}};
        misalign = 1'b0;
      end
      2'b01: begin
        be       = req_addr[1] ? 4'b1100 : 4'b0011;
        wrep     = {2{req_wdata[15:0]}};
        misalign = req_addr[0];
      end
      default: ;
    endcase
  end

  // Requests are only taken in IDLE; in IO_REQ/IO_DONE the held request is the one in flight.
  assign accept   = (state_q == IDLE) & (req_we | req_re);
  assign is_mmio  = req_addr >= MMIO_BASE;
  assign bad      = accept & misalign;
  assign ram_we   = accept & ~misalign & ~is_mmio & req_we;
  assign ram_re   = accept & ~misalign & ~is_mmio & ~req_we;
  assign io_start = accept & ~misalign & is_mmio;
  assign idx      = req_addr[AW+1:2];

  assign stall      = rst_n & ((state_q == IO_REQ) | io_start);
  assign misaligned = misaligned_q;
  assign dbg_state  = state_q;
  assign rdata      = ram_load_q ? load_extend(ram_rd_q, lane_q, size_q, uns_q) : rdata_q;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wrep[8*i +: 8];
      end
    end
    if (ram_re) ram_rd_q <= mem[idx];
  end

  always_comb begin
    rdata_d = rdata;
    if (bad) rdata_d = '0;
    else if (state_q == IO_DONE && !io_we) rdata_d = load_extend(io_hold_q, lane_q, size_q, uns_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_load_q   <= 1'b0;
      misaligned_q <= 1'b0;
      rdata_q      <= '0;
      lane_q       <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
    end else begin
      ram_load_q   <= ram_re;
      misaligned_q <= bad;
      rdata_q      <= rdata_d;
      if (ram_re | io_start) begin
        lane_q <= req_addr[1:0];
        size_q <= req_bytes;
        uns_q  <= req_unsigned;
      end
    end
  end

  // Peripheral transfer FSM; io_* stay stable from issue until completion or timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      io_hold_q <= '0;
      io_valid  <= 1'b0;
      io_addr   <= '0;
      io_wdata  <= '0;
      io_be     <= '0;
      io_we     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (io_start) begin
            state_q  <= IO_REQ;
            cnt_q    <= '0;
            io_valid <= 1'b1;
            io_addr  <= {req_addr[31:2], 2'b00};
            io_be    <= be;
            io_wdata <= wrep;
            io_we    <= req_we;
          end
        end
        IO_REQ: begin
          if (io_ready) begin
            io_hold_q <= io_rdata;
            io_valid  <= 1'b0;
            state_q   <= IO_DONE;
          end else if (cnt_q == CW'(IO_TIMEOUT - 1)) begin
            io_hold_q <= 32'hFFFF_FFFF;
            io_valid  <= 1'b0;
            state_q   <= IO_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        IO_DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder: a transaction-level model (byte memory,
// extension arithmetic, MMIO latency rules) predicts every output each cycle.
module tb_dmem_responder;
  localparam int DEPTH = 256;
  localparam logic [31:0] MMIO_BASE = 32'hFFFF_0000;
  localparam int TMO = 64;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0, io_rdata = '0;
  logic        req_we = 1'b0, req_re = 1'b0, req_unsigned = 1'b0, io_ready = 1'b0;
  logic [1:0]  req_bytes = '0;
  logic [31:0] rdata, io_addr, io_wdata;
  logic        stall, misaligned, io_valid, io_we;
  logic [3:0]  io_be;
  logic [1:0]  dbg_state;

  dmem_responder #(.DEPTH(DEPTH), .MMIO_BASE(MMIO_BASE), .IO_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req_addr(req_addr), .req_wdata(req_wdata), .req_we(req_we),
    .req_re(req_re), .req_bytes(req_bytes), .req_unsigned(req_unsigned), .rdata(rdata),
    .stall(stall), .misaligned(misaligned), .io_valid(io_valid), .io_addr(io_addr),
    .io_wdata(io_wdata), .io_be(io_be), .io_we(io_we), .io_ready(io_ready),
    .io_rdata(io_rdata), .dbg_state(dbg_state));

  always #5 clk = ~clk;

  // Model state
  logic [31:0] mem_m [DEPTH];
  logic [31:0] exp_rdata = '0, nxt_rdata = '0;
  logic        exp_mis = 1'b0, nxt_mis = 1'b0, exp_stall = 1'b0, exp_iov = 1'b0;
  logic [31:0] exp_io_addr = '0, exp_io_wdata = '0;
  logic [3:0]  exp_io_be = '0;
  logic        exp_io_we = 1'b0;
  logic        chk_en = 1'b0;
  int          n_checks = 0, n_err = 0, stall_cnt = 0, iov_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rdata", rdata, exp_rdata);
      chk("stall", {31'b0, stall}, {31'b0, exp_stall});
      chk("misaligned", {31'b0, misaligned}, {31'b0, exp_mis});
      chk("io_valid", {31'b0, io_valid}, {31'b0, exp_iov});
      if (exp_iov) begin
        chk("io_addr", io_addr, exp_io_addr);
        chk("io_wdata", io_wdata, exp_io_wdata);
        chk("io_be", {28'b0, io_be}, {28'b0, exp_io_be});
        chk("io_we", {31'b0, io_we}, {31'b0, exp_io_we});
      end
      if (stall) stall_cnt++;
      if (io_valid) iov_cnt++;
    end
  end

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] w, input int lane, input int n,
                                         input logic uns);
    logic [31:0] mask, v;
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    v = (w >> (8 * lane)) & mask;
    if (!uns && n < 4 && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [31:0] replicate(input logic [31:0] wd, input int n);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  task automatic begin_cycle();
    @(posedge clk);
    #1;
    exp_rdata = nxt_rdata;
    exp_mis   = nxt_mis;
    nxt_mis   = 1'b0;
  endtask

  task automatic idle();
    begin_cycle();
    req_we = 1'b0; req_re = 1'b0; io_ready = 1'b0;
    req_addr = $urandom; req_wdata = $urandom;
    exp_stall = 1'b0; exp_iov = 1'b0;
  endtask

  // One request; MMIO requests are held until consumed. rdy_at = valid cycle (1-based)
  // on which io_ready rises, 0 or >TMO = never.
  task automatic xfer(input logic [31:0] a, input logic [31:0] wd, input logic we, input logic re,
                      input logic [1:0] sz, input logic uns, input int rdy_at, input logic [31:0] iod);
    int n, nv, widx;
    logic [3:0] be;
    logic [31:0] rep;
    begin_cycle();
    req_addr = a; req_wdata = wd; req_we = we; req_re = re; req_bytes = sz; req_unsigned = uns;
    io_ready = 1'b0;
    exp_stall = 1'b0; exp_iov = 1'b0;
    if (!(we | re)) return;
    n = nbytes(sz);
    if (a % n != 0) begin
      nxt_mis = 1'b1;
      nxt_rdata = '0;
      return;
    end
    be  = 4'(((1 << n) - 1) << (a % 4));
    rep = replicate(wd, n);
    if (a < MMIO_BASE) begin
      widx = int'((a / 4) % DEPTH);
      if (we) begin
        for (int i = 0; i < 4; i++) if (be[i]) mem_m[widx][8*i +: 8] = rep[8*i +: 8];
      end else begin
        nxt_rdata = extend(mem_m[widx], int'(a % 4), n, uns);
      end
      return;
    end
    exp_stall = 1'b1;
    exp_io_addr = a & ~32'd3; exp_io_be = be; exp_io_wdata = rep; exp_io_we = we;
    nv = (rdy_at >= 1 && rdy_at <= TMO) ? rdy_at : TMO;
    for (int k = 1; k <= nv; k++) begin
      begin_cycle();
      exp_stall = 1'b1; exp_iov = 1'b1;
      io_ready = (k == rdy_at);
      io_rdata = (k == rdy_at) ? iod : $urandom;
    end
    begin_cycle();
    io_ready = 1'b0; exp_stall = 1'b0; exp_iov = 1'b0;
    if (!we) nxt_rdata = extend((nv == rdy_at) ? iod : 32'hFFFF_FFFF, int'(a % 4), n, uns);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int r, kind, rdy;
    logic [31:0] a;
    #12;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_mis", {31'b0, misaligned}, 32'h0);
    chk("rst_io_valid", {31'b0, io_valid}, 32'h0);
    chk("rst_io_addr", io_addr, 32'h0);
    chk("rst_io_wdata", io_wdata, 32'h0);
    chk("rst_io_be", {28'b0, io_be}, 32'h0);
    chk("rst_io_we", {31'b0, io_we}, 32'h0);
    @(posedge clk); #3; rst_n = 1'b1; chk_en = 1'b1;

    for (int i = 0; i < DEPTH; i++) xfer(32'(i * 4), $urandom, 1'b1, 1'b0, 2'b10, 1'b0, 0, 0);

    // Sub-word store and sign/zero extended loads
    xfer(32'h0, 32'h1122_3344, 1, 0, 2'b10, 0, 0, 0);
    xfer(32'h3, 32'h0000_00A5, 1, 0, 2'b00, 0, 0, 0);
    xfer(32'h3, 32'h0, 0, 1, 2'b00, 0, 0, 0);
    idle(); chk("lb_a5", rdata, 32'hFFFF_FFA5);
    xfer(32'h3, 32'h0, 0, 1, 2'b00, 1, 0, 0);
    idle(); chk("lbu_a5", rdata, 32'h0000_00A5);
    xfer(32'h0, 32'h0, 0, 1, 2'b10, 0, 0, 0);
    idle(); chk("lw_after_sb", rdata, 32'hA522_3344);

    // Store-then-load forwarding, misalignment
    xfer(32'h10, 32'h1234_5678, 1, 0, 2'b10, 0, 0, 0);
    xfer(32'h12, 32'h0, 0, 1, 2'b01, 0, 0, 0);
    idle(); chk("lh_12", rdata, 32'h0000_1234);
    xfer(32'h11, 32'h0, 0, 1, 2'b01, 0, 0, 0);
    idle(); chk("mis_pulse", {31'b0, misaligned}, 32'h1); chk("mis_rdata", rdata, 32'h0);
    xfer(32'h12, 32'hFFFF_FFFF, 1, 0, 2'b10, 0, 0, 0);
    xfer(32'h10, 32'h0, 0, 1, 2'b10, 0, 0, 0);
    idle(); chk("ram_unchanged", rdata, 32'h1234_5678);

    // MMIO load, ready on third valid cycle
    stall_cnt = 0; iov_cnt = 0;
    xfer(32'hFFFF_0004, 32'h0, 0, 1, 2'b10, 0, 3, 32'hCAFE_0001);
    idle(); idle();
    chk("mmio_rdata", rdata, 32'hCAFE_0001);
    chk("mmio_stall_cycles", 32'(stall_cnt), 32'd4);
    chk("mmio_valid_cycles", 32'(iov_cnt), 32'd3);

    // MMIO timeout, and ready arriving on the last allowed cycle
    stall_cnt = 0; iov_cnt = 0;
    xfer(32'hFFFF_0010, 32'h0, 0, 1, 2'b10, 0, 0, 0);
    idle(); idle();
    chk("tmo_rdata", rdata, 32'hFFFF_FFFF);
    chk("tmo_valid_cycles", 32'(iov_cnt), 32'(TMO));
    chk("tmo_stall_cycles", 32'(stall_cnt), 32'(TMO + 1));
    xfer(32'hFFFF_0020, 32'h0, 0, 1, 2'b10, 0, TMO, 32'h0BAD_F00D);
    idle(); idle(); chk("ready_wins", rdata, 32'h0BAD_F00D);

    // Reset in the middle of an MMIO transfer
    xfer(32'h20, 32'h5555_AAAA, 1, 0, 2'b10, 0, 0, 0);
    xfer(32'h20, 32'h0, 0, 1, 2'b10, 0, 0, 0);
    idle(); chk("pre_rst_rdata", rdata, 32'h5555_AAAA);
    begin_cycle();
    req_addr = 32'hFFFF_0008; req_we = 0; req_re = 1; req_bytes = 2'b10; req_unsigned = 0;
    exp_stall = 1; exp_iov = 0;
    exp_io_addr = 32'hFFFF_0008; exp_io_be = 4'hF; exp_io_wdata = req_wdata; exp_io_we = 0;
    begin_cycle(); exp_iov = 1;
    begin_cycle();
    #2; chk_en = 0; rst_n = 1'b0; #1;
    chk("rst_async_io_valid", {31'b0, io_valid}, 32'h0);
    chk("rst_async_stall", {31'b0, stall}, 32'h0);
    req_re = 0; nxt_rdata = '0; exp_rdata = '0; nxt_mis = 0; exp_stall = 0; exp_iov = 0;
    repeat (2) @(posedge clk);
    #3; rst_n = 1'b1;
    begin_cycle(); chk_en = 1'b1;
    chk("post_rst_state", {30'b0, dbg_state}, 32'h0);
    chk("post_rst_rdata", rdata, 32'h0);
    for (int i = 0; i < 4; i++) begin
      begin_cycle(); io_ready = 1'b1; io_rdata = $urandom;
    end
    idle(); chk("no_stale_rdata", rdata, 32'h0);

    // Index wrap-around
    xfer(32'(4 * DEPTH), 32'hDEAD_BEEF, 1, 0, 2'b10, 0, 0, 0);
    xfer(32'h0, 32'h0, 0, 1, 2'b10, 0, 0, 0);
    idle(); chk("alias_word0", rdata, 32'hDEAD_BEEF);

    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 99);
      kind = $urandom_range(0, 3);
      if (r < 10) begin
        idle();
      end else if (r < 82) begin
        a = 32'($urandom_range(0, 8 * DEPTH - 1));
        xfer(a, $urandom, kind == 0 || kind == 2, kind != 0, 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 0, 0);
      end else begin
        a = MMIO_BASE + 32'($urandom_range(0, 16'hFFFF));
        rdy = ($urandom_range(0, 24) == 0) ? 0 : $urandom_range(1, 5);
        xfer(a, $urandom, kind == 0 || kind == 2, kind != 0, 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), rdy, $urandom);
      end
    end
    idle(); idle();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder at the memory-access stage. Answers the load/store requests the exec stage issues on the cycle they are presented.
- Addresses below MMIO_BASE go to an internal byte-enabled synchronous RAM with 1-cycle read latency. It performs sub-word lane steering and sign/zero extension.
- Addresses at or above MMIO_BASE go to a valid/ready peripheral port. The block stalls the pipeline while such a transfer is outstanding, with a timeout.

Parameters:
- DEPTH, 16384, RAM size in 32-bit words (power of two).
- MMIO_BASE, 32'hFFFF_0000, first MMIO byte address.
- IO_TIMEOUT, 64, max cycles waiting for io_ready before forced completion.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- req_addr  in  32  byte address (exec data_addr).
- req_wdata  in  32  store data, unaligned in lane 0 (exec data_to_memory).
- req_we  in  1  store request (exec data_memory_we).
- req_re  in  1  load request.
- req_bytes  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal (treated as word).
- req_unsigned  in  1  zero-extend load (lbu/lhu).
- rdata  out  32  extended load result, valid the cycle after the load completes.
- stall  out  1  freeze pipeline stages up to and including exec.
- misaligned  out  1  1-cycle pulse, cycle after an illegal-alignment request.
- io_valid  out  1  MMIO request valid.
- io_addr  out  32  word-aligned MMIO address.
- io_wdata  out  32  lane-steered store data.
- io_be  out  4  byte enables.
- io_we  out  1  MMIO write.
- io_ready  in  1  peripheral accepts/completes the transfer this cycle.
- io_rdata  in  32  peripheral read word, sampled with io_ready.

Behaviour:
- Reset (async, rst_n=0): rdata=0, stall=0, misaligned=0, io_valid=0, io_addr=0, io_wdata=0, io_be=0, io_we=0. FSM goes to IDLE, timeout counter=0, RAM contents untouched. Reset during an MMIO transfer drops io_valid immediately; no completion is reported.
- Request cycle: req_we|req_re sampled at the rising edge. If both are set, the store wins and no load is performed.
- Byte enables from addr[1:0] and size:
  - byte: 1<<addr[1:0]
  - half: 0011 or 1100
  - word: 1111
  - Write data replicated into every lane.
- Alignment: half with addr[0]=1, or word with addr[1:0]!=0, is misaligned. The store is suppressed, no MMIO issue, misaligned=1 next cycle, rdata=0 next cycle.
- RAM path (addr < MMIO_BASE):
  - Index = addr[log2(DEPTH)+1:2]; higher bits are ignored (wrap-around).
  - Store commits at the request edge.
  - Load: RAM read at the request edge; rdata appears the next cycle, steered by the registered addr[1:0], size and unsigned.
  - Store at edge N followed by a load of the same word at edge N+1 returns the new data.
  - stall stays 0 on the RAM path.
- rdata holds its previous value in cycles following a non-load.
- MMIO FSM states IDLE, IO_REQ, IO_DONE. Transitions:
  - IDLE: an aligned MMIO request sets stall=1 combinationally in the same cycle and latches addr/be/wdata/we. Next state is IO_REQ.
  - IO_REQ: io_valid=1, outputs stable, stall=1, counter increments.
    - io_ready=1: capture io_rdata into rdata_hold; go to IO_DONE.
    - Counter reaches IO_TIMEOUT-1 without io_ready: rdata_hold=32'hFFFF_FFFF, io_valid drops, go to IO_DONE.
    - io_ready and timeout in the same cycle: io_ready wins.
  - IO_DONE: stall=0, io_valid=0. The still-held request on req_* is consumed (not reissued); rdata in the next cycle is rdata_hold steered/extended. Next state is IDLE unconditionally.
- MMIO store completes with rdata unchanged.
- MMIO requests while the FSM is not IDLE are impossible because the pipeline is stalled; no queueing is done.

Test Plan:
- Byte store 8'hA5 to 0x0000_0003, then lb and lbu of 0x0000_0003 -> rdata 32'hFFFF_FFA5 then 32'h0000_00A5; the other three bytes of the word are unchanged.
- sw 32'h1234_5678 to 0x10, lh at 0x12 next cycle -> rdata 32'h0000_1234 one cycle after the load; lh at 0x11 -> misaligned=1 for 1 cycle, rdata=0, RAM unchanged.
- lw at 0xFFFF_0004 with io_ready asserted 3 cycles after io_valid -> stall high 4 cycles; io_addr 0xFFFF_0004, io_be 1111; io_rdata 32'hCAFE_0001 appears on rdata the cycle after IO_DONE; no second io_valid.
- MMIO lw with io_ready never asserted -> io_valid high exactly IO_TIMEOUT cycles, then rdata 32'hFFFF_FFFF, stall released.
- rst_n low while in IO_REQ -> io_valid and stall drop asynchronously; after release the FSM is IDLE and no stale rdata update occurs.
- Store to index DEPTH (byte addr 4*DEPTH) -> aliases to word 0; lw 0x0 returns the stored value.
